// File: rtl/dmem_store_buffer_if.sv
// Store-buffer bus: core store/load-lookup side plus memory drain side.
// The buffer takes the slave modport; the core/memory side takes master.
interface dmem_store_buffer_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int CW = 3
);
  logic          memwrite;
  logic [AW-1:0] dataadr;
  logic [DW-1:0] writedata;
  logic          stall;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic          ld_hit;
  logic [DW-1:0] ld_data;
  logic          mem_wvalid;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wready;
  logic          empty;
  logic [CW-1:0] count;

  modport master (
    output memwrite, dataadr, writedata,
    output ld_en, ld_addr, mem_wready,
    input  stall, ld_hit, ld_data,
    input  mem_wvalid, mem_waddr, mem_wdata,
    input  empty, count
  );

  modport slave (
    input  memwrite, dataadr, writedata,
    input  ld_en, ld_addr, mem_wready,
    output stall, ld_hit, ld_data,
    output mem_wvalid, mem_waddr, mem_wdata,
    output empty, count
  );
endinterface

// File: rtl/dmem_store_buffer.sv
// In-order store buffer between MEM stage and data memory,
// with youngest-match word forwarding to loads.
module dmem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input logic             clk,
  input logic             rst,
  dmem_store_buffer_if.slave sb
);
  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = PW - 1;

  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [AW-1:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic          r_hit;
  logic [DW-1:0] r_ld;

  logic [PW-1:0] w_count;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_hit;
  logic [DW-1:0] w_fdata;
  logic [IW-1:0] w_idx;
  logic          w_unused;

  assign w_count = r_wptr - r_rptr;
  assign w_empty = (w_count == '0);
  assign w_full  = (w_count == PW'(DEPTH));
  assign w_push  = sb.memwrite & ~w_full;
  assign w_pop   = ~w_empty & sb.mem_wready;

  // Oldest to youngest, so the last match wins; same-edge store is youngest.
  always_comb begin
    w_hit   = 1'b0;
    w_fdata = '0;
    w_idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_rptr[IW-1:0] + IW'(k);
      if (PW'(k) < w_count &&
          r_addr[w_idx][AW-1:2] == sb.ld_addr[AW-1:2]) begin
        w_hit   = 1'b1;
        w_fdata = r_data[w_idx];
      end
    end
    if (w_push &&
        sb.dataadr[AW-1:2] == sb.ld_addr[AW-1:2]) begin
      w_hit   = 1'b1;
      w_fdata = sb.writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_hit  <= 1'b0;
      r_ld   <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + PW'(1);
      if (w_pop)
        r_rptr <= r_rptr + PW'(1);
      r_hit <= sb.ld_en & w_hit;
      if (sb.ld_en & w_hit)
        r_ld <= w_fdata;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wptr[IW-1:0]] <= sb.dataadr;
      r_data[r_wptr[IW-1:0]] <= sb.writedata;
    end
  end

  assign sb.stall      = sb.memwrite & w_full;
  assign sb.mem_wvalid = ~w_empty;
  assign sb.mem_waddr  = r_addr[r_rptr[IW-1:0]];
  assign sb.mem_wdata  = r_data[r_rptr[IW-1:0]];
  assign sb.ld_hit     = r_hit;
  assign sb.ld_data    = r_ld;
  assign sb.empty      = w_empty;
  assign sb.count      = w_count;

  assign w_unused = ^sb.ld_addr[1:0];
endmodule

// File: tb/tb_dmem_store_buffer.sv
// Self-checking bench for dmem_store_buffer: vector table,
// directed corner sequences and random traffic vs a queue model.
module tb_dmem_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int CW    = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_store_buffer_if #(.AW(AW), .DW(DW), .CW(CW)) sb();

  dmem_store_buffer #(
    .DEPTH(DEPTH), .AW(AW), .DW(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sb (sb)
  );

  typedef struct {
    logic        mw;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        le;
    logic [31:0] la;
    logic        wr;
    logic        e_stall;
    logic        e_wv;
    logic [31:0] e_wa;
    logic [31:0] e_wd;
    int          e_cnt;
    logic        e_hit;
    logic [31:0] e_ld;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  vec_t        tv[$];
  ent_t        mq[$];
  logic        m_hit = 1'b0;
  logic [31:0] m_ld  = '0;
  logic [31:0] obs_a[$];
  logic [31:0] obs_d[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic row(logic mw, int adr, int wd,
                     logic le, int la, logic wr,
                     logic es, logic ev, int ea, int ed,
                     int ec, logic eh, int el);
    vec_t v;
    v.mw = mw; v.adr = adr; v.wd = wd;
    v.le = le; v.la = la; v.wr = wr;
    v.e_stall = es; v.e_wv = ev;
    v.e_wa = ea; v.e_wd = ed;
    v.e_cnt = ec; v.e_hit = eh; v.e_ld = el;
    tv.push_back(v);
  endtask

  task automatic drive(logic r, logic mw, logic [31:0] adr,
                       logic [31:0] wd, logic le,
                       logic [31:0] la, logic wr);
    rst          = r;
    sb.memwrite  = mw;
    sb.dataadr   = adr;
    sb.writedata = wd;
    sb.ld_en     = le;
    sb.ld_addr   = la;
    sb.mem_wready = wr;
  endtask

  // Queue-level reference: search, then pop head, then append.
  function automatic void model_edge();
    bit          full, push, pop, hit;
    logic [31:0] d;
    ent_t        e;
    if (rst) begin
      mq.delete();
      m_hit = 1'b0;
      m_ld  = '0;
      return;
    end
    full = (mq.size() == DEPTH);
    push = sb.memwrite && !full;
    pop  = (mq.size() != 0) && sb.mem_wready;
    hit  = 1'b0;
    d    = '0;
    if (sb.ld_en) begin
      foreach (mq[k])
        if (mq[k].a[31:2] == sb.ld_addr[31:2]) begin
          hit = 1'b1;
          d   = mq[k].d;
        end
      if (push && sb.dataadr[31:2] == sb.ld_addr[31:2]) begin
        hit = 1'b1;
        d   = sb.writedata;
      end
    end
    m_hit = hit;
    if (hit) m_ld = d;
    if (pop) void'(mq.pop_front());
    if (push) begin
      e.a = sb.dataadr;
      e.d = sb.writedata;
      mq.push_back(e);
    end
  endfunction

  task automatic check_model(string tag);
    chk({tag, "_stall"}, sb.stall,
        sb.memwrite && mq.size() == DEPTH);
    chk({tag, "_wvalid"}, sb.mem_wvalid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk({tag, "_waddr"}, sb.mem_waddr, mq[0].a);
      chk({tag, "_wdata"}, sb.mem_wdata, mq[0].d);
    end
    chk({tag, "_count"}, sb.count, mq.size());
    chk({tag, "_empty"}, sb.empty, mq.size() == 0);
    chk({tag, "_hit"}, sb.ld_hit, m_hit);
    if (m_hit)
      chk({tag, "_ldata"}, sb.ld_data, m_ld);
  endtask

  task automatic to_neg();
    @(negedge clk);
    if (sb.mem_wvalid === 1'b1 && sb.mem_wready) begin
      obs_a.push_back(sb.mem_waddr);
      obs_d.push_back(sb.mem_wdata);
    end
  endtask

  task automatic to_pos();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic mcycle(string tag);
    to_neg();
    check_model(tag);
    to_pos();
  endtask

  initial begin
    bit held;
    logic [31:0] ha, hd;

    // Vector table: inputs for the cycle, expected outputs seen
    // mid-cycle (state after the previous edge).
    row(1,100,25, 0,0,  1, 0,0,0,0,     0,0,0);
    row(0,0,0,    0,0,  1, 0,1,100,25,  1,0,0);
    row(0,0,0,    0,0,  0, 0,0,0,0,     0,0,0);
    row(1,0,'h10, 0,0,  0, 0,0,0,0,     0,0,0);
    row(1,4,'h11, 0,0,  0, 0,1,0,'h10,  1,0,0);
    row(1,8,'h12, 0,0,  0, 0,1,0,'h10,  2,0,0);
    row(1,12,'h13,0,0,  0, 0,1,0,'h10,  3,0,0);
    row(1,16,'h14,0,0,  0, 1,1,0,'h10,  4,0,0);
    row(1,16,'h14,0,0,  1, 1,1,0,'h10,  4,0,0);
    row(1,16,'h14,0,0,  0, 0,1,4,'h11,  3,0,0);
    row(0,0,0,    0,0,  1, 0,1,4,'h11,  4,0,0);
    row(0,0,0,    0,0,  1, 0,1,8,'h12,  3,0,0);
    row(0,0,0,    0,0,  1, 0,1,12,'h13, 2,0,0);
    row(0,0,0,    0,0,  1, 0,1,16,'h14, 1,0,0);
    row(0,0,0,    0,0,  0, 0,0,0,0,     0,0,0);
    row(1,96,7,   0,0,  0, 0,0,0,0,     0,0,0);
    row(1,96,9,   0,0,  0, 0,1,96,7,    1,0,0);
    row(0,0,0,    1,98, 0, 0,1,96,7,    2,0,0);
    row(0,0,0,    1,200,0, 0,1,96,7,    2,1,9);
    row(0,0,0,    0,0,  1, 0,1,96,7,    2,0,0);
    row(0,0,0,    0,0,  1, 0,1,96,9,    1,0,0);
    row(1,100,25, 1,100,0, 0,0,0,0,     0,0,0);
    row(0,0,0,    0,0,  1, 0,1,100,25,  1,1,25);
    row(0,0,0,    0,0,  0, 0,0,0,0,     0,0,0);

    drive(1, 0, 0, 0, 0, 0, 0);
    to_pos();
    to_pos();
    drive(0, 0, 0, 0, 0, 0, 0);
    to_neg();
    chk("rst_count", sb.count, 0);
    chk("rst_empty", sb.empty, 1);
    chk("rst_wvalid", sb.mem_wvalid, 0);
    chk("rst_hit", sb.ld_hit, 0);
    chk("rst_ldata", sb.ld_data, 0);
    to_pos();

    foreach (tv[i]) begin
      drive(0, tv[i].mw, tv[i].adr, tv[i].wd,
            tv[i].le, tv[i].la, tv[i].wr);
      to_neg();
      chk($sformatf("v%0d_stall", i), sb.stall, tv[i].e_stall);
      chk($sformatf("v%0d_wvalid", i), sb.mem_wvalid,
          tv[i].e_wv);
      if (tv[i].e_wv) begin
        chk($sformatf("v%0d_waddr", i), sb.mem_waddr,
            tv[i].e_wa);
        chk($sformatf("v%0d_wdata", i), sb.mem_wdata,
            tv[i].e_wd);
      end
      chk($sformatf("v%0d_count", i), sb.count, tv[i].e_cnt);
      chk($sformatf("v%0d_empty", i), sb.empty,
          tv[i].e_cnt == 0);
      chk($sformatf("v%0d_hit", i), sb.ld_hit, tv[i].e_hit);
      if (tv[i].e_hit)
        chk($sformatf("v%0d_ldata", i), sb.ld_data,
            tv[i].e_ld);
      to_pos();
    end

    // Wrap-around: push and pop every cycle.
    obs_a.delete();
    obs_d.delete();
    for (int i = 0; i < 3 * DEPTH; i++) begin
      drive(0, 1, 32'(4 * i), 32'(i), 0, 0, 1);
      mcycle("wrap");
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    for (int n = 0; n < 20 && mq.size() != 0; n++)
      mcycle("wrapd");
    chk("wrap_n", obs_a.size(), 3 * DEPTH);
    for (int i = 0; i < 3 * DEPTH && i < obs_a.size(); i++) begin
      chk($sformatf("wrap_a%0d", i), obs_a[i], 32'(4 * i));
      chk($sformatf("wrap_d%0d", i), obs_d[i], 32'(i));
    end

    // Reset while entries are pending and a hit is registered.
    drive(0, 1, 200, 1, 0, 0, 0);
    mcycle("r6");
    drive(0, 1, 204, 2, 0, 0, 0);
    mcycle("r6");
    drive(0, 1, 208, 3, 1, 204, 0);
    mcycle("r6");
    drive(1, 0, 0, 0, 0, 0, 0);
    to_neg();
    chk("r6_pre_count", sb.count, 3);
    chk("r6_pre_hit", sb.ld_hit, 1);
    chk("r6_pre_ldata", sb.ld_data, 2);
    to_pos();
    drive(0, 0, 0, 0, 1, 200, 0);
    to_neg();
    chk("r6_count", sb.count, 0);
    chk("r6_empty", sb.empty, 1);
    chk("r6_wvalid", sb.mem_wvalid, 0);
    chk("r6_hit", sb.ld_hit, 0);
    to_pos();
    drive(0, 0, 0, 0, 0, 0, 0);
    to_neg();
    chk("r6_lookup_hit", sb.ld_hit, 0);
    to_pos();

    // Random traffic against the queue model.
    held = 1'b0;
    ha = '0;
    hd = '0;
    for (int i = 0; i < 400; i++) begin
      logic        mw;
      logic [31:0] a, d;
      mw = ($urandom_range(0, 3) != 0);
      a  = 32'($urandom_range(0, 7)) * 4 +
           32'($urandom_range(0, 3));
      d  = $urandom;
      if (held) begin
        mw = 1'b1;
        a  = ha;
        d  = hd;
      end
      drive(($urandom_range(0, 99) == 0), mw, a, d,
            $urandom_range(0, 1),
            32'($urandom_range(0, 7)) * 4 +
            32'($urandom_range(0, 3)),
            ($urandom_range(0, 2) == 0));
      held = !rst && mw && mq.size() == DEPTH;
      ha = a;
      hd = d;
      mcycle("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_store_buffer.md
Name: dmem_store_buffer

Overview:
- Responder end of the core's data-memory write port (memwrite / dataadr / writedata).
- Accepts stores from RISC_V_pipeline_top into an in-order FIFO and drains them to the data memory over a valid/ready handshake.
- Provides store-to-load forwarding for pending stores and a stall to the core when the buffer is full.
- Sits between the pipeline's MEM stage and the data memory.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, minimum 2.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- memwrite  in  1  store request from the core.
- dataadr  in  AW  store byte address; compared on [AW-1:2].
- writedata  in  DW  store data.
- stall  out  1  buffer full; store not accepted this cycle.
- ld_en  in  1  load lookup request.
- ld_addr  in  AW  load byte address.
- ld_hit  out  1  registered; a pending store matched the previous cycle's lookup.
- ld_data  out  DW  registered forwarded data; valid only when ld_hit=1.
- mem_wvalid  out  1  head entry presented to memory.
- mem_waddr  out  AW  head entry address.
- mem_wdata  out  DW  head entry data.
- mem_wready  in  1  memory accepts the head entry.
- empty  out  1  no pending stores.
- count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset (rst=1 at a rising edge):
  - Read/write pointers, count, ld_hit and ld_data are cleared; empty=1, stall=0, mem_wvalid=0.
  - Stored entries are discarded, including any pending in-flight drain. Reset has priority over every other event.
- Storage:
  - DEPTH x {addr, data} array.
  - Read and write pointers are $clog2(DEPTH)+1 bits wide; the extra bit distinguishes full from empty.
  - Pointers wrap modulo 2*DEPTH.
- Enqueue:
  - Occurs when memwrite=1 and full=0; the entry is written at the write pointer on that edge.
  - stall = memwrite & full (combinational from registered full).
  - A stalled store is not captured; the core holds memwrite/dataadr/writedata stable until stall=0.
- Drain:
  - mem_wvalid = !empty. mem_waddr and mem_wdata come straight from the head entry.
  - These outputs are stable while mem_wvalid=1 and mem_wready=0.
  - A pop occurs on the edge where mem_wvalid & mem_wready.
  - mem_wready is ignored while empty.
- Simultaneous push and pop:
  - When full: the pop completes, the push is rejected (stall=1), and count drops by 1. There is no full-bypass.
  - When neither full nor empty: both complete and count is unchanged.
  - When empty: only the push occurs. There is no empty-bypass; mem_wvalid rises the next cycle.
- Ordering: stores reach memory strictly in acceptance order. There is no coalescing and no reordering.
- Forwarding:
  - On an edge with ld_en=1, the buffer searches all valid entries present before that edge, plus the store accepted on that same edge.
  - Matches are compared on address bits [AW-1:2].
  - The youngest match wins; a same-cycle accepted store is the youngest.
  - An entry popped on the same edge still participates in the search.
  - ld_hit and ld_data update one cycle after ld_en.
  - ld_en=0 clears ld_hit and holds ld_data. No match gives ld_hit=0.
  - Forwarding is full-word only; byte and half stores are outside the scope of this block.
- count / empty: both are registered, with count = wptr - rptr. full is asserted when count == DEPTH.

Test Plan:
1. Reset then a single store: memwrite=1, dataadr=100, writedata=25 for 1 cycle, mem_wready=1 -> next cycle mem_wvalid=1, mem_waddr=100, mem_wdata=25, count=1; the following cycle count=0, empty=1.
2. Fill with mem_wready=0: store to addresses 0, 4, 8, 12, then a 5th store to 16 -> count=4 and stall=1 on the 5th. Raise mem_wready for 1 cycle -> stall drops the cycle after. Drain order is 0, 4, 8, 12, 16.
3. Forwarding youngest-wins: store (96, 7) then (96, 9) with mem_wready=0, then ld_en with ld_addr=98 -> next cycle ld_hit=1, ld_data=9. A lookup at 200 -> ld_hit=0.
4. Same-cycle store and lookup: memwrite with (100, 25) and ld_en with ld_addr=100 on the same edge -> next cycle ld_hit=1, ld_data=25.
5. Wrap-around: continuously push and pop 3*DEPTH stores with addresses 4*i and data i -> the memory side sees exactly i=0..3*DEPTH-1 in order, with no loss or duplication.
6. Reset mid-operation: with 3 pending entries and mem_wready=0, assert rst for 1 cycle -> count=0, empty=1, mem_wvalid=0, ld_hit=0. A subsequent lookup on a previously buffered address -> ld_hit=0.
